// File: rtl/dsp_share_arbiter_pkg.sv
// Shared constants and types for the DSP48A1 sharing arbiter: bundle layout,
// FSM encoding and a bundle packing helper.
package dsp_share_arbiter_pkg;

  localparam int DSP_INS_W  = 92;
  localparam int DSP_OUTS_W = 84;
  localparam int OPMODE_LSB = 84;
  localparam int A_LSB      = 66;
  localparam int B_LSB      = 48;
  localparam int C_LSB      = 0;
  localparam int OWNER_W    = 3;

  localparam logic [DSP_INS_W-1:0] DSP_NOP = '0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [7:0]  opmode;
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] c;
  } dsp_ins_t;

  function automatic logic [DSP_INS_W-1:0] dsp_pack(input logic [7:0]  opmode,
                                                    input logic [17:0] a,
                                                    input logic [17:0] b,
                                                    input logic [47:0] c);
    dsp_ins_t s;
    s.opmode = opmode;
    s.a      = a;
    s.b      = b;
    s.c      = c;
    return s;
  endfunction

endpackage

// File: rtl/dsp_share_arbiter_if.sv
// Requester-side bus of the DSP sharing arbiter: per-requester req and input
// bundles in, one-hot grant and the muxed DSP bundle out.
interface dsp_share_arbiter_if
  import dsp_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]           req;
  logic [DSP_INS_W*N_REQ-1:0] req_dsp_ins_flat;
  logic [N_REQ-1:0]           gnt;
  logic [DSP_INS_W-1:0]       dsp_ins_flat;
  logic [OWNER_W-1:0]         owner_id;
  logic                       busy;
  logic                       err_clr;
  logic                       err_conflict;
  logic                       err_timeout;

  modport master (
    output req, req_dsp_ins_flat, err_clr,
    input  gnt, dsp_ins_flat, owner_id, busy, err_conflict, err_timeout
  );

  modport slave (
    input  req, req_dsp_ins_flat, err_clr,
    output gnt, dsp_ins_flat, owner_id, busy, err_conflict, err_timeout
  );

endinterface

// File: rtl/dsp_share_arbiter_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// searching cyclically. Reusable by any shared-resource arbiter.
module arb_rr_pick
  import dsp_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [OWNER_W:0] sum;

  // Rotating the doubled vector puts rr_ptr at bit 0, so priority is plain LSB-first.
  assign rot = N_REQ'({req, req} >> rr_ptr);

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path
    // that never assigns it would infer a latch.
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!valid && rot[j]) begin
        valid = 1'b1;
        sum   = {1'b0, rr_ptr} + (OWNER_W + 1)'(j);
        if (sum >= (OWNER_W + 1)'(N_REQ)) begin
          sum = sum - (OWNER_W + 1)'(N_REQ);
        end
        idx = sum[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dsp_share_arbiter.sv
// Round-robin owner of the single DSP48A1 slice: grants one requester a burst,
// muxes its bundle to the DSP, then drains the M/P pipeline before regranting.
module dsp_share_arbiter
  import dsp_share_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_HOLD     = 0
) (
  input logic               clk,
  input logic               reset,
  dsp_share_arbiter_if.slave bus
);

  localparam int HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [OWNER_W-1:0] owner_id_q, owner_id_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               busy_q, busy_d;
  logic               err_conflict_q, err_conflict_d;
  logic               err_timeout_q, err_timeout_d;

  logic [DSP_INS_W-1:0] slices [N_REQ];
  logic [N_REQ-1:0]     slice_nz;
  logic [DSP_INS_W-1:0] dsp_mux;
  logic                 req_owner;
  logic                 pick_valid;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 conflict_hit;
  logic                 hold_expired;
  logic                 revoke;

  arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slices[i]   = bus.req_dsp_ins_flat[DSP_INS_W*i +: DSP_INS_W];
      slice_nz[i] = |slices[i];
    end
  end

  // Select rather than OR: the DSP sees only the owner, and NOP outside GRANT.
  always_comb begin
    dsp_mux   = DSP_NOP;
    req_owner = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_id_q == OWNER_W'(i)) begin
        req_owner = bus.req[i];
        if (state_q == ARB_GRANT) begin
          dsp_mux = slices[i];
        end
      end
    end
  end

  assign conflict_hit = |(~gnt_q & slice_nz);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign revoke       = !req_owner || hold_expired;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_id_d  = owner_id_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_timeout_d  = err_timeout_q;
    err_conflict_d = err_conflict_q;
    if (bus.err_clr) begin
      err_timeout_d  = 1'b0;
      err_conflict_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_GRANT;
          gnt_d      = N_REQ'(1) << pick_idx;
          owner_id_d = pick_idx;
          rr_ptr_d   = (pick_idx == OWNER_W'(N_REQ - 1)) ? '0 : pick_idx + OWNER_W'(1);
          hold_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (revoke) begin
          gnt_d       = '0;
          drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
          state_d     = (DRAIN_CYCLES == 0) ? ARB_IDLE : ARB_DRAIN;
          if (req_owner) begin
            err_timeout_d = 1'b1;
          end
        end
      end
      ARB_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q <= DRAIN_W'(1)) begin
          drain_cnt_d = '0;
          state_d     = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Set wins over a coincident clear.
    if (conflict_hit) begin
      err_conflict_d = 1'b1;
    end
    busy_d = (state_d != ARB_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      gnt_q          <= '0;
      owner_id_q     <= '0;
      rr_ptr_q       <= '0;
      hold_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      busy_q         <= 1'b0;
      err_conflict_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      owner_id_q     <= owner_id_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      busy_q         <= busy_d;
      err_conflict_q <= err_conflict_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.dsp_ins_flat = dsp_mux;
  assign bus.owner_id     = owner_id_q;
  assign bus.busy         = busy_q;
  assign bus.err_conflict = err_conflict_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Directed bench for dsp_share_arbiter: reset, latency, round-robin order,
// MAX_HOLD timeout, conflict flags and asynchronous reset mid-burst.
module tb_dsp_share_arbiter;
  import dsp_share_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  dsp_share_arbiter_if #(.N_REQ(4)) bus ();

  dsp_share_arbiter #(
    .N_REQ        (4),
    .DRAIN_CYCLES (2),
    .MAX_HOLD     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [DSP_INS_W-1:0] v);
    bus.req_dsp_ins_flat[DSP_INS_W*i +: DSP_INS_W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [DSP_INS_W-1:0] s0;
    logic [DSP_INS_W-1:0] s1;
    int exp_order [5];
    int waited;
    int cnt;
    int k;

    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.req_dsp_ins_flat = '0;
    bus.err_clr = 1'b0;
    step(2);

    // Reset values
    check("rst_gnt", bus.gnt, 0);
    check("rst_dsp", bus.dsp_ins_flat, 0);
    check("rst_owner", bus.owner_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_errc", bus.err_conflict, 0);
    check("rst_errt", bus.err_timeout, 0);
    reset = 1'b0;
    step(1);

    // Single burst: 1-cycle grant latency, combinational mux, drain timing
    s0 = dsp_pack(8'h05, 18'h10000, 18'h0, 48'h0);
    bus.req = 4'b0001;
    #1;
    check("t1_gnt_pre", bus.gnt, 0);
    step(1);
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_owner", bus.owner_id, 0);
    check("t1_busy", bus.busy, 1);
    set_slice(0, s0);
    #1;
    check("t1_dsp", bus.dsp_ins_flat, s0);
    step(6);
    check("t1_gnt_hold", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    set_slice(0, '0);
    step(1);
    check("t1_gnt_fall", bus.gnt, 0);
    check("t1_dsp_nop", bus.dsp_ins_flat, 0);
    check("t1_busy_drain0", bus.busy, 1);
    step(1);
    check("t1_busy_drain1", bus.busy, 1);
    step(1);
    check("t1_busy_idle", bus.busy, 0);
    check("t1_errc", bus.err_conflict, 0);
    check("t1_errt", bus.err_timeout, 0);

    // Round robin with all four requesting, 4-cycle bursts, 3-cycle gaps
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (bus.gnt == 4'b0000 && waited < 10) begin
        step(1);
        waited++;
      end
      k = exp_order[g];
      check("rr_gnt", bus.gnt, 4'b0001 << k);
      check("rr_owner", bus.owner_id, k);
      if (g > 0) check("rr_gap", waited, 3);
      s1 = dsp_pack(8'(g + 1), 18'(k + 1), 18'h3, 48'(g + 7));
      set_slice(k, s1);
      #1;
      check("rr_dsp", bus.dsp_ins_flat, s1);
      step(3);
      bus.req[k] = 1'b0;
      set_slice(k, '0);
      step(1);
      check("rr_gnt_fall", bus.gnt, 0);
      if (g == 0) bus.req[0] = 1'b1;
    end
    bus.req = 4'b0000;
    step(3);
    check("rr_idle", bus.busy, 0);
    check("rr_errc", bus.err_conflict, 0);

    // MAX_HOLD=8: requester 2 held forever is revoked after 8 grant cycles
    bus.req = 4'b0100;
    step(1);
    check("to_gnt", bus.gnt, 4'b0100);
    set_slice(2, dsp_pack(8'h11, 18'h22, 18'h33, 48'h44));
    bus.req[3] = 1'b1;
    cnt = 0;
    while (bus.gnt == 4'b0100 && cnt < 20) begin
      cnt++;
      step(1);
    end
    set_slice(2, '0);
    check("to_len", cnt, 8);
    check("to_errt", bus.err_timeout, 1);
    waited = 0;
    while (bus.gnt == 4'b0000 && waited < 10) begin
      step(1);
      waited++;
    end
    check("to_next", bus.gnt, 4'b1000);
    step(1);
    bus.req = 4'b0000;
    step(4);
    check("to_errc", bus.err_conflict, 0);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("to_clr", bus.err_timeout, 0);

    // Conflict: a non-owner drives a non-zero bundle
    do_reset();
    s0 = dsp_pack(8'h05, 18'h10000, 18'h0, 48'h0);
    s1 = dsp_pack(8'h00, 18'h00001, 18'h0, 48'h0);
    bus.req = 4'b0001;
    step(1);
    check("cf_gnt", bus.gnt, 4'b0001);
    set_slice(0, s0);
    set_slice(1, s1);
    #1;
    check("cf_dsp", bus.dsp_ins_flat, s0);
    check("cf_pre", bus.err_conflict, 0);
    step(1);
    set_slice(1, '0);
    check("cf_set", bus.err_conflict, 1);
    step(1);
    check("cf_sticky", bus.err_conflict, 1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("cf_clr", bus.err_conflict, 0);
    bus.err_clr = 1'b1;
    set_slice(1, s1);
    step(1);
    bus.err_clr = 1'b0;
    set_slice(1, '0);
    check("cf_set_wins", bus.err_conflict, 1);
    bus.req = 4'b0000;
    set_slice(0, '0);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("cf_clr2", bus.err_conflict, 0);
    step(3);

    // Asynchronous reset in the 5th cycle of a burst
    bus.req = 4'b0001;
    step(1);
    check("ar_gnt", bus.gnt, 4'b0001);
    set_slice(0, s0);
    step(4);
    reset = 1'b1;
    #1;
    check("ar_gnt0", bus.gnt, 0);
    check("ar_dsp0", bus.dsp_ins_flat, 0);
    check("ar_busy0", bus.busy, 0);
    bus.req = 4'b0100;
    set_slice(0, '0);
    step(1);
    reset = 1'b0;
    step(1);
    check("ar_gnt2", bus.gnt, 4'b0100);
    check("ar_owner2", bus.owner_id, 2);
    step(1);
    bus.req = 4'b0000;
    step(4);
    // Pointer sits at 3 here; after reset it must search from 0 again
    reset = 1'b1;
    step(1);
    bus.req = 4'b1001;
    reset = 1'b0;
    step(1);
    check("ar_rr_restart", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    step(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
